// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between two requesters. Each requester has a valid/ready
// request channel (operands + command) and a valid/ready response channel.
// The block arbitrates, registers the winning operands, runs the ALU for one
// cycle, captures result and flags, then holds the response for the owner
// until it is consumed.
//
// Ports:
//   clk, reset          sole clock (rising edge), synchronous active-high reset
//   reqN_valid/ready    request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b      operands from requester N
//   reqN_cmd            ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT,
//                       4 AND, 5 NAND, 6 NOR, 7 OR
//   rspN_valid/ready    response handshake for requester N
//   rsp_result          captured ALU result (shared by both response ports)
//   rsp_carryout/zero/overflow  captured ALU flags
//   busy                high whenever the arbiter is not idle
//
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN  defined: round-robin priority between the ports.
//                           undefined: fixed priority, port 0 wins ties.
// -----------------------------------------------------------------------------

// Combinational 32-bit style ALU. ADD/SUB/SLT share one adder; SUB and SLT
// feed the inverted B operand with a carry-in of one. Carry and overflow are
// only meaningful for ADD and SUB and read as zero for the other commands.
module ALU #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  logic             isSub;
  logic [WIDTH-1:0] addB;
  logic [WIDTH:0]   sum;
  logic             addOvf;

  assign isSub  = (command == CMD_SUB) || (command == CMD_SLT);
  assign addB   = isSub ? ~operandB : operandB;
  assign sum    = {1'b0, operandA} + {1'b0, addB} + {{WIDTH{1'b0}}, isSub};
  // Signed overflow: both adder inputs share a sign that the sum does not.
  assign addOvf = (operandA[WIDTH-1] == addB[WIDTH-1]) &&
                  (sum[WIDTH-1] != operandA[WIDTH-1]);

  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (command)
      CMD_ADD, CMD_SUB: begin
        result   = sum[WIDTH-1:0];
        carryout = sum[WIDTH];
        overflow = addOvf;
      end
      CMD_XOR:  result = operandA ^ operandB;
      // Sign of a-b corrected for overflow gives a true signed less-than.
      CMD_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ addOvf};
      CMD_AND:  result = operandA & operandB;
      CMD_NAND: result = ~(operandA & operandB);
      CMD_NOR:  result = ~(operandA | operandB);
      CMD_OR:   result = operandA | operandB;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_cmd,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [1:0]       rspValid_q, rspValid_d;
  logic             busy_q, busy_d;

  logic             anyReq, tieWinner, winner, transfer;
  logic [WIDTH-1:0] aluResult;
  logic             aluCarry, aluZero, aluOvf;

  ALU #(.WIDTH(WIDTH)) uAlu (
    .operandA (a_q),
    .operandB (b_q),
    .command  (cmd_q),
    .result   (aluResult),
    .carryout (aluCarry),
    .zero     (aluZero),
    .overflow (aluOvf)
  );

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // ptr_q names the port that wins the next tie.
  logic ptr_q, ptr_d;
  assign tieWinner = ptr_q;
`else
  assign tieWinner = 1'b0;
`endif

  assign anyReq   = req0_valid || req1_valid;
  assign winner   = (req0_valid && req1_valid) ? tieWinner : req1_valid;
  assign transfer = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  // Ready is withheld during reset so no requester sees a handshake that the
  // arbiter is about to discard.
  assign req0_ready = !reset && (state_q == IDLE) && anyReq && !winner;
  assign req1_ready = !reset && (state_q == IDLE) && anyReq &&  winner;

  assign rsp0_valid   = rspValid_q[0];
  assign rsp1_valid   = rspValid_q[1];
  assign rsp_result   = result_q;
  assign rsp_carryout = carry_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
  assign busy         = busy_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    cmd_d      = cmd_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    rspValid_d = rspValid_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d = EXEC;
          owner_d = winner;
          a_d     = winner ? req1_a   : req0_a;
          b_d     = winner ? req1_b   : req0_b;
          cmd_d   = winner ? req1_cmd : req0_cmd;
        end
      end
      EXEC: begin
        result_d   = aluResult;
        carry_d    = aluCarry;
        zero_d     = aluZero;
        ovf_d      = aluOvf;
        rspValid_d = owner_q ? 2'b10 : 2'b01;
        state_d    = RESP;
      end
      RESP: begin
        if (transfer) begin
          rspValid_d = 2'b00;
          state_d    = IDLE;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          // The port just served drops to lowest priority.
          ptr_d      = ~owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rspValid_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cmd_q      <= cmd_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      rspValid_q <= rspValid_d;
      busy_q     <= busy_d;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Scoreboard bench for alu_arbiter. Requests are issued by per-port stimulus
// tasks which push the expected response onto that port's queue once the
// request is accepted. An independent monitor pops and compares on every
// response transfer, and also tracks arbitration order, response latency,
// busy, and response stability under backpressure against a behavioural
// model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] result;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  localparam longint MAX_S = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MIN_S = -64'sh0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  reqValid = 2'b00;
  logic [31:0] reqA [2];
  logic [31:0] reqB [2];
  logic [2:0]  reqCmd [2];
  logic [1:0]  rspReady;
  logic        req0Ready, req1Ready, rsp0Valid, rsp1Valid;
  logic [31:0] rspResult;
  logic        rspCarry, rspZero, rspOvf, busy;

  int checks = 0;
  int errors = 0;
  exp_t expQ0[$];
  exp_t expQ1[$];

  bit         randomReadyEn = 1'b0;
  logic [1:0] dirReady = 2'b11;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (reqValid[0]),
    .req0_ready   (req0Ready),
    .req0_a       (reqA[0]),
    .req0_b       (reqB[0]),
    .req0_cmd     (reqCmd[0]),
    .req1_valid   (reqValid[1]),
    .req1_ready   (req1Ready),
    .req1_a       (reqA[1]),
    .req1_b       (reqB[1]),
    .req1_cmd     (reqCmd[1]),
    .rsp0_valid   (rsp0Valid),
    .rsp0_ready   (rspReady[0]),
    .rsp1_valid   (rsp1Valid),
    .rsp1_ready   (rspReady[1]),
    .rsp_result   (rspResult),
    .rsp_carryout (rspCarry),
    .rsp_zero     (rspZero),
    .rsp_overflow (rspOvf),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its required value.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mkExp(input logic [31:0] r, input logic c, input logic z, input logic o);
    exp_t e;
    e.result = r;
    e.c = c;
    e.z = z;
    e.o = o;
    return e;
  endfunction

  // Behavioural ALU: plain wide arithmetic on unsigned/signed interpretations.
  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
    exp_t e;
    longint unsigned ua, ub;
    longint sa, sb, sr;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.c = 1'b0;
    e.o = 1'b0;
    e.result = '0;
    case (cmd)
      3'd0: begin
        e.result = a + b;
        e.c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        sr = sa + sb;
        e.o = (sr > MAX_S) || (sr < MIN_S);
      end
      3'd1: begin
        e.result = a - b;
        e.c = (ua >= ub);
        sr = sa - sb;
        e.o = (sr > MAX_S) || (sr < MIN_S);
      end
      3'd2: e.result = a ^ b;
      3'd3: e.result = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: e.result = a & b;
      3'd5: e.result = ~(a & b);
      3'd6: e.result = ~(a | b);
      default: e.result = a | b;
    endcase
    e.z = (e.result == 32'd0);
    return e;
  endfunction

`ifdef ALU_ARB_ROUND_ROBIN_EN
  bit modelPtr = 1'b0;
`endif

  // Which port the arbitration rules say must be granted for a valid pattern.
  function automatic logic [1:0] expectedGrant(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return modelPtr ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    return v;
  endfunction

  // Response-ready driver: directed value or random backpressure.
  initial begin
    rspReady = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      if (randomReadyEn)
        rspReady = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      else
        rspReady = dirReady;
    end
  end

  // Present one request (called at posedge+1), wait for its grant, push the
  // expected response, and return at posedge+1 of the cycle after acceptance.
  task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] cmd, input exp_t e,
                               input bit doPush, input bit keepValid);
    bit got;
    int waited;
    reqValid[port] = 1'b1;
    reqA[port]     = a;
    reqB[port]     = b;
    reqCmd[port]   = cmd;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 100) begin
      @(negedge clk);
      if ((port == 0) ? req0Ready : req1Ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grantTimeout port=%0d actual=no_ready required=ready", port);
    end else if (doPush) begin
      if (port == 0) expQ0.push_back(e);
      else           expQ1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keepValid) reqValid[port] = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((expQ0.size() != 0 || expQ1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drainPending", 64'(expQ0.size() + expQ1.size()), 64'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic randomDriver(input int port, input int n);
    logic [31:0] a, b;
    logic [2:0]  cmd;
    bit          keep;
    int          gap;
    for (int i = 0; i < n; i++) begin
      a    = randOperand();
      b    = randOperand();
      cmd  = 3'($urandom_range(0, 7));
      keep = (i != n - 1) && ($urandom_range(0, 1) == 1);
      applyStimulus(port, a, b, cmd, refModel(a, b, cmd), 1'b1, keep);
      if (!keep) begin
        gap = int'($urandom_range(0, 3));
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Monitor: arbitration, latency, busy, stability and scoreboard compare.
  bit         modelIdle = 1'b1;
  bit         grantPending = 1'b0;
  logic [1:0] grantOwner = 2'b00;
  int         sinceGrant = 0;
  bit         prevAny = 1'b0;
  bit         prevHeld = 1'b0;
  bit         prevTransfer = 1'b0;
  logic [31:0] prevResult = '0;
  logic [2:0]  prevFlags = '0;
  logic [1:0]  prevValids = '0;

  task automatic checkResponse(input int port);
    exp_t e;
    if ((port == 0 && expQ0.size() == 0) || (port == 1 && expQ1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedRsp port=%0d actual=response required=none", port);
    end else begin
      e = (port == 0) ? expQ0.pop_front() : expQ1.pop_front();
      checkOutput($sformatf("p%0dResult", port), 64'(rspResult), 64'(e.result));
      checkOutput($sformatf("p%0dFlags", port), 64'({rspCarry, rspZero, rspOvf}),
                  64'({e.c, e.z, e.o}));
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] valids;
    logic [1:0] g;
    bit         xfer;
    if (reset) begin
      modelIdle    = 1'b1;
      grantPending = 1'b0;
      prevAny      = 1'b0;
      prevHeld     = 1'b0;
      prevTransfer = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      modelPtr     = 1'b0;
`endif
    end else begin
      valids = {rsp1Valid, rsp0Valid};
      if (grantPending) sinceGrant++;
      checkOutput("busy", 64'(busy), 64'(!modelIdle));
      if (modelIdle) begin
        if (reqValid != 2'b00) begin
          g = expectedGrant(reqValid);
          checkOutput("grant", 64'({req1Ready, req0Ready}), 64'(g));
          modelIdle    = 1'b0;
          grantPending = 1'b1;
          grantOwner   = g;
          sinceGrant   = 0;
        end
      end else if (reqValid != 2'b00) begin
        checkOutput("readyWhileBusy", 64'({req1Ready, req0Ready}), 64'd0);
      end
      if (prevTransfer) checkOutput("validDrop", 64'(valids), 64'd0);
      if (valids != 2'b00 && !prevAny) begin
        if (!grantPending) begin
          checkOutput("spuriousRsp", 64'(valids), 64'd0);
        end else begin
          checkOutput("rspLatency", 64'(sinceGrant), 64'd2);
          checkOutput("rspOwner", 64'(valids), 64'(grantOwner));
          grantPending = 1'b0;
        end
      end
      if (prevHeld) begin
        checkOutput("holdResult", 64'(rspResult), 64'(prevResult));
        checkOutput("holdFlags", 64'({rspCarry, rspZero, rspOvf}), 64'(prevFlags));
        checkOutput("holdValid", 64'(valids), 64'(prevValids));
      end
      xfer = 1'b0;
      if (rsp0Valid && rspReady[0]) begin
        xfer = 1'b1;
        checkResponse(0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        modelPtr = 1'b1;
`endif
      end else if (rsp1Valid && rspReady[1]) begin
        xfer = 1'b1;
        checkResponse(1);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        modelPtr = 1'b0;
`endif
      end
      if (xfer) modelIdle = 1'b1;
      prevTransfer = xfer;
      prevAny      = (valids != 2'b00);
      prevHeld     = (valids != 2'b00) && !xfer;
      prevResult   = rspResult;
      prevFlags    = {rspCarry, rspZero, rspOvf};
      prevValids   = valids;
    end
  end

  initial begin
    reqA[0] = '0; reqA[1] = '0;
    reqB[0] = '0; reqB[1] = '0;
    reqCmd[0] = '0; reqCmd[1] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values.
    @(negedge clk);
    checkOutput("resetRspValid", 64'({rsp1Valid, rsp0Valid}), 64'd0);
    checkOutput("resetResult", 64'(rspResult), 64'd0);
    checkOutput("resetFlags", 64'({rspCarry, rspZero, rspOvf}), 64'd0);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetReqReady", 64'({req1Ready, req0Ready}), 64'd0);
    @(posedge clk);
    #1;

    // Single ADD on port 0.
    applyStimulus(0, 32'd4, 32'd2, 3'd0, mkExp(32'd6, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    waitIdle();

    // Simultaneous requests straight after reset: port 0 first.
    doReset();
    fork
      applyStimulus(0, 32'd5, 32'd3, 3'd0, mkExp(32'd8, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
      applyStimulus(1, 32'd5, 32'd5, 3'd1, mkExp(32'd0, 1'b1, 1'b1, 1'b0), 1'b1, 1'b0);
    join
    waitIdle();

    // Both ports held valid continuously; the monitor checks grant order.
    fork
      begin
        applyStimulus(0, 32'd10, 32'd1, 3'd0, mkExp(32'd11, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        applyStimulus(0, 32'd20, 32'd2, 3'd0, mkExp(32'd22, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        applyStimulus(0, 32'd30, 32'd3, 3'd0, mkExp(32'd33, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
      end
      begin
        applyStimulus(1, 32'hF0, 32'h0F, 3'd7, mkExp(32'hFF, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        applyStimulus(1, 32'd7, 32'd7, 3'd2, mkExp(32'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
        applyStimulus(1, 32'hC, 32'hA, 3'd4, mkExp(32'h8, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
      end
    join
    waitIdle();

    // Overflow and carry corners on port 1.
    applyStimulus(1, 32'h7FFF_FFFF, 32'd1, 3'd0, mkExp(32'h8000_0000, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    applyStimulus(1, 32'hFFFF_FFFF, 32'd1, 3'd0, mkExp(32'h0, 1'b1, 1'b1, 1'b0), 1'b1, 1'b0);
    waitIdle();

    // Backpressure on port 0 while port 1 waits.
    dirReady = 2'b10;
    @(posedge clk);
    #1;
    applyStimulus(0, 32'h1234, 32'h1111, 3'd0, mkExp(32'h2345, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    fork
      applyStimulus(1, 32'd9, 32'd4, 3'd1, mkExp(32'd5, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
      begin
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        dirReady = 2'b11;
      end
    join
    waitIdle();

    // Reset while the operation is in EXEC: no response may appear.
    applyStimulus(0, 32'd1, 32'd1, 3'd0, mkExp(32'd2, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("execResetBusy", 64'(busy), 64'd0);
    checkOutput("execResetRspValid", 64'({rsp1Valid, rsp0Valid}), 64'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(0, 32'd100, 32'd23, 3'd0, mkExp(32'd123, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    waitIdle();

    // Signed less-than.
    applyStimulus(0, 32'd3, 32'd5, 3'd3, mkExp(32'd1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    applyStimulus(0, 32'd5, 32'd3, 3'd3, mkExp(32'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
    waitIdle();

    // Random traffic on both ports with random response backpressure.
    randomReadyEn = 1'b1;
    fork
      randomDriver(0, 30);
      randomDriver(1, 30);
    join
    randomReadyEn = 1'b0;
    dirReady = 2'b11;
    waitIdle();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
